// File: rtl/match_flow_controller_pkg.sv
// Shared definitions for the match flow controller: state and winner encodings
// (same numbering the renderer and HUD decode) and a saturating score helper.
package match_flow_controller_pkg;

  typedef enum logic [2:0] {
    STATE_MENU       = 3'd0,
    STATE_COUNTDOWN  = 3'd1,
    STATE_GAMEPLAY   = 3'd2,
    STATE_MATCH_OVER = 3'd3,
    STATE_PAUSE      = 3'd4,
    STATE_ROUND_END  = 3'd5,
    STATE_RSVD6      = 3'd6,
    STATE_RSVD7      = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    WINNER_NONE = 2'd0,
    WINNER_P1   = 2'd1,
    WINNER_P2   = 2'd2
  } winner_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] score, input logic [3:0] limit);
    return (score >= limit) ? limit : score + 4'd1;
  endfunction

endpackage

// File: rtl/match_flow_controller_counter.sv
// Loadable down-counter that stops at zero; used for the countdown timer and
// the round-end hold.
module flow_tick_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_game,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk_game or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/match_flow_controller.sv
// Top-level game-flow FSM: menu, countdown, gameplay with pause, round-end hold
// and best-of-N match scoring. Control outputs are Moore-decoded from state.
module match_flow_controller
  import match_flow_controller_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC   = 60,
  parameter int unsigned COUNT_SECS      = 3,
  parameter int unsigned ROUNDS_TO_WIN   = 2,
  parameter int unsigned ROUND_END_TICKS = 120
) (
  input  logic       clk_game,
  input  logic       reset,
  input  logic       btn_confirm,
  input  logic       btn_pause,
  input  logic       mode_2p,
  input  logic       round_over,
  input  logic       round_winner_p2,
  input  logic       round_draw,
  output logic [2:0] game_state,
  output logic [7:0] countdown_value,
  output logic       game_mode_1p,
  output logic       start_round,
  output logic       reset_gameplay,
  output logic       timer_enable,
  output logic       timer_reset,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] match_winner
);

  localparam int unsigned CD_TICKS  = COUNT_SECS * TICKS_PER_SEC;
  localparam int unsigned CD_W      = $clog2(CD_TICKS + 1);
  localparam int unsigned HOLD_W    = $clog2(ROUND_END_TICKS + 1);
  localparam logic [3:0]  WIN_SCORE = 4'(ROUNDS_TO_WIN);

  state_t      r_state, w_next_state;
  logic [3:0]  r_p1_score, r_p2_score, w_p1_nxt, w_p2_nxt, w_p1_inc, w_p2_inc;
  winner_t     r_match_winner, w_winner_nxt;
  logic        r_mode_1p, w_mode_1p_nxt;
  logic        r_confirm_prev, r_pause_prev;
  logic        w_confirm_edge, w_pause_edge;
  logic        w_cd_load, w_cd_dec, w_cd_zero;
  logic        w_hold_load, w_hold_dec, w_hold_zero;
  logic [CD_W-1:0]   w_cd_count;
  logic [HOLD_W-1:0] w_hold_count_unused;

  assign w_confirm_edge = btn_confirm & ~r_confirm_prev;
  assign w_pause_edge   = btn_pause & ~r_pause_prev;
  assign w_p1_inc       = sat_inc(r_p1_score, WIN_SCORE);
  assign w_p2_inc       = sat_inc(r_p2_score, WIN_SCORE);

  flow_tick_counter #(.W(CD_W)) u_cd_timer (
    .clk_game   (clk_game),
    .reset      (reset),
    .i_load     (w_cd_load),
    .i_load_val (CD_W'(CD_TICKS)),
    .i_dec      (w_cd_dec),
    .o_count    (w_cd_count),
    .o_zero     (w_cd_zero)
  );

  flow_tick_counter #(.W(HOLD_W)) u_round_end_hold (
    .clk_game   (clk_game),
    .reset      (reset),
    .i_load     (w_hold_load),
    .i_load_val (HOLD_W'(ROUND_END_TICKS)),
    .i_dec      (w_hold_dec),
    .o_count    (w_hold_count_unused),
    .o_zero     (w_hold_zero)
  );

  always_ff @(posedge clk_game or posedge reset) begin
    if (reset) begin
      r_state        <= STATE_MENU;
      r_p1_score     <= '0;
      r_p2_score     <= '0;
      r_match_winner <= WINNER_NONE;
      r_mode_1p      <= 1'b0;
      r_confirm_prev <= 1'b0;
      r_pause_prev   <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_p1_score     <= w_p1_nxt;
      r_p2_score     <= w_p2_nxt;
      r_match_winner <= w_winner_nxt;
      r_mode_1p      <= w_mode_1p_nxt;
      r_confirm_prev <= btn_confirm;
      r_pause_prev   <= btn_pause;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_p1_nxt        = r_p1_score;
    w_p2_nxt        = r_p2_score;
    w_winner_nxt    = r_match_winner;
    w_mode_1p_nxt   = r_mode_1p;
    w_cd_dec        = 1'b0;
    w_hold_dec      = 1'b0;
    countdown_value = 8'hFF;
    start_round     = 1'b0;
    reset_gameplay  = 1'b1;
    timer_enable    = 1'b0;
    timer_reset     = 1'b0;

    case (r_state)
      STATE_MENU: begin
        timer_reset   = 1'b1;
        w_mode_1p_nxt = ~mode_2p;
        if (w_confirm_edge) begin
          w_next_state = STATE_COUNTDOWN;
          w_p1_nxt     = '0;
          w_p2_nxt     = '0;
          w_winner_nxt = WINNER_NONE;
        end
      end
      STATE_COUNTDOWN: begin
        timer_reset     = 1'b1;
        w_cd_dec        = 1'b1;
        countdown_value = 8'((32'(w_cd_count) + TICKS_PER_SEC - 1) / TICKS_PER_SEC);
        if (w_cd_zero) begin
          start_round  = 1'b1;
          w_next_state = STATE_GAMEPLAY;
        end
      end
      STATE_GAMEPLAY: begin
        reset_gameplay = 1'b0;
        timer_enable   = 1'b1;
        // round_over outranks a simultaneous pause edge
        if (round_over) begin
          w_next_state = STATE_ROUND_END;
          if (!round_draw && !round_winner_p2) begin
            w_p1_nxt = w_p1_inc;
            if (w_p1_inc == WIN_SCORE) begin
              w_next_state = STATE_MATCH_OVER;
              w_winner_nxt = WINNER_P1;
            end
          end else if (!round_draw) begin
            w_p2_nxt = w_p2_inc;
            if (w_p2_inc == WIN_SCORE) begin
              w_next_state = STATE_MATCH_OVER;
              w_winner_nxt = WINNER_P2;
            end
          end
        end else if (w_pause_edge) begin
          w_next_state = STATE_PAUSE;
        end
      end
      STATE_PAUSE: begin
        reset_gameplay = 1'b0;
        if (w_pause_edge) w_next_state = STATE_GAMEPLAY;
      end
      STATE_ROUND_END: begin
        w_hold_dec = 1'b1;
        if (w_hold_zero) w_next_state = STATE_COUNTDOWN;
      end
      STATE_MATCH_OVER: begin
        reset_gameplay = 1'b0;
        timer_enable   = 1'b1;
        if (w_confirm_edge) w_next_state = STATE_MENU;
      end
      default: begin
        timer_reset  = 1'b1;
        w_next_state = STATE_MENU;
      end
    endcase

    w_cd_load   = (w_next_state == STATE_COUNTDOWN) && (r_state != STATE_COUNTDOWN);
    w_hold_load = (w_next_state == STATE_ROUND_END) && (r_state != STATE_ROUND_END);
  end

  assign game_state   = r_state;
  assign game_mode_1p = r_mode_1p;
  assign p1_score     = r_p1_score;
  assign p2_score     = r_p2_score;
  assign match_winner = r_match_winner;

endmodule
